// File: rtl/input_port_buffer_pkg.sv
// Shared NoC definitions for the router input port: flit type codes,
// output port codes and FSM state encoding.
package input_port_buffer_pkg;

    // Default flit MSB index (flit is FLIT_FW+1 bits wide)
    localparam int FLIT_FW = 39;

    // Output port codes; 000 is not a legal route
    localparam logic [2:0] PORT_NONE  = 3'b000;
    localparam logic [2:0] PORT_LOCAL = 3'b001;

    // Flit type lives in the two MSBs of every flit
    typedef enum logic [1:0] {
        FT_SINGLE = 2'b00,
        FT_HEAD   = 2'b01,
        FT_BODY   = 2'b10,
        FT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUTE = 2'b01,
        ST_REQ   = 2'b10,
        ST_XFER  = 2'b11
    } ibuf_state_e;

    // Head and single flits open a packet; body and tail continue one
    function automatic logic starts_packet(input logic [1:0] ftype);
        return !ftype[1];
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Circular flit FIFO; the head word is visible combinationally.
module noc_flit_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk_t,
    input  logic         rst_t,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally mod DEPTH; count tracks occupancy
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // Storage needs no reset: it is only observed while non-empty
    always_ff @(posedge clk_t) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: buffers flits, obtains a route for each packet head
// from rcu_mod, then requests the switch and forwards the whole packet
// on that port (wormhole) until its tail leaves.
module input_port_buffer
    import input_port_buffer_pkg::*;
#(
    parameter int FW      = FLIT_FW,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int RCU_LAT = 1
) (
    input  logic        clk_t,
    input  logic        rst_t,
    input  logic        in_valid,
    input  logic [FW:0] in_flit,
    output logic        in_ready,
    output logic [FW:0] rcu_flit,
    input  logic [2:0]  rcu_op,
    output logic        sa_req,
    output logic [2:0]  sa_port,
    input  logic        sa_grant,
    output logic        out_valid,
    output logic [FW:0] out_flit,
    output logic        out_tail,
    output logic        err
);

    localparam int CW = (RCU_LAT < 1) ? 1 : $clog2(RCU_LAT + 1);

    ibuf_state_e   state, state_nxt;
    logic [CW-1:0] lat_cnt, lat_cnt_nxt;
    logic [2:0]    route_reg, route_nxt;
    logic          err_nxt;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW:0]   head;
    logic [1:0]    head_type;
    logic          ov_nxt;
    logic          ot_nxt;

    noc_flit_fifo #(.W(FW + 1), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk_t (clk_t),
        .rst_t (rst_t),
        .push  (in_valid && in_ready),
        .wdata (in_flit),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // in_ready is held low while reset is asserted
    assign in_ready  = rst_t && !fifo_full;
    assign rcu_flit  = fifo_empty ? '0 : head;
    assign head_type = head[FW:FW-1];
    assign sa_req    = (state == ST_REQ) || (state == ST_XFER);
    assign sa_port   = sa_req ? route_reg : '0;

    // Packet FSM: route lookup, switch request and flit forwarding
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        route_nxt   = route_reg;
        err_nxt     = err;
        pop         = 1'b0;
        ov_nxt      = 1'b0;
        ot_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (starts_packet(head_type)) begin
                        state_nxt   = ST_ROUTE;
                        lat_cnt_nxt = '0;
                    end else begin
                        // Orphan body/tail: drop it silently and flag it
                        pop     = 1'b1;
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_ROUTE: begin
                if (lat_cnt == CW'(RCU_LAT)) begin
                    state_nxt = ST_REQ;
                    if (rcu_op == PORT_NONE) begin
                        route_nxt = PORT_LOCAL;
                        err_nxt   = 1'b1;
                    end else begin
                        route_nxt = rcu_op;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                end
            end
            ST_REQ: begin
                if (sa_grant && !fifo_empty) begin
                    pop    = 1'b1;
                    ov_nxt = 1'b1;
                    if (head_type == FT_SINGLE) begin
                        ot_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (sa_grant && !fifo_empty) begin
                    pop    = 1'b1;
                    ov_nxt = 1'b1;
                    if (head_type == FT_TAIL) begin
                        ot_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (starts_packet(head_type)) begin
                        // New packet start inside a packet: close the worm here
                        ot_nxt    = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, route latch, sticky error and registered output beat
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            route_reg <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_tail  <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            route_reg <= route_nxt;
            err       <= err_nxt;
            out_valid <= ov_nxt;
            out_flit  <= ov_nxt ? head : '0;
            out_tail  <= ot_nxt;
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: directed packet scenarios plus randomized
// traffic, all checked each cycle against a queue-based packet model.
module tb_input_port_buffer;

    localparam int FW      = 39;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int RCU_LAT = 1;
    localparam int NEVER   = 32'h7fff_ffff;

    logic        clk_t = 1'b0;
    logic        rst_t = 1'b0;
    logic        in_valid = 1'b0;
    logic [FW:0] in_flit = '0;
    logic [2:0]  rcu_op = '0;
    logic        sa_grant = 1'b0;
    logic        in_ready;
    logic [FW:0] rcu_flit;
    logic        sa_req;
    logic [2:0]  sa_port;
    logic        out_valid;
    logic [FW:0] out_flit;
    logic        out_tail;
    logic        err;

    input_port_buffer #(.FW(FW), .DEPTH(DEPTH), .AW(AW), .RCU_LAT(RCU_LAT)) dut (
        .clk_t     (clk_t),
        .rst_t     (rst_t),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .rcu_flit  (rcu_flit),
        .rcu_op    (rcu_op),
        .sa_req    (sa_req),
        .sa_port   (sa_port),
        .sa_grant  (sa_grant),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_tail  (out_tail),
        .err       (err)
    );

    always #5 clk_t = ~clk_t;

    int nvec = 0;
    int nerr = 0;

    // Model: stored flits, the open packet and when its request goes up
    logic [FW:0] q[$];
    bit          active;
    bit          first;
    int          req_cyc;
    int          err_at;
    int          t;
    logic [2:0]  route;
    logic        m_ov;
    logic        m_ot;
    logic [FW:0] m_of;
    bit          gen_pkt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [FW:0] mk_flit(input logic [1:0] ty, input logic [2:0] op);
        logic [FW:0] f;
        f = (FW+1)'({$urandom(), $urandom()});
        f[FW -: 2] = ty;
        f[2:0] = op;
        return f;
    endfunction

    task automatic model_clear();
        q.delete();
        active = 0;
        first = 0;
        req_cyc = NEVER;
        err_at = NEVER;
        route = '0;
        m_ov = 0;
        m_ot = 0;
        m_of = '0;
    endtask

    task automatic compare();
        bit exp_req;
        exp_req = active && (t >= req_cyc);
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("rcu_flit", rcu_flit, (q.size() > 0) ? q[0] : '0);
        chk("sa_req", sa_req, exp_req);
        chk("sa_port", sa_port, exp_req ? route : 3'b000);
        chk("out_valid", out_valid, m_ov);
        chk("out_flit", out_flit, m_of);
        chk("out_tail", out_tail, m_ot);
        chk("err", err, t >= err_at);
    endtask

    // One clock of packet behaviour, derived from the flit-type rules
    task automatic model_step(input logic v, input logic [FW:0] f, input logic g);
        logic [FW:0] h;
        bit accept;
        accept = v && (q.size() < DEPTH);
        m_ov = 0;
        m_ot = 0;
        m_of = '0;
        if (q.size() > 0) begin
            h = q[0];
            if (!active) begin
                if (h[FW] == 1'b0) begin
                    active  = 1;
                    first   = 1;
                    req_cyc = t + 2 + RCU_LAT;
                    route   = h[2:0];
                    if (route == 3'b000) begin
                        route = 3'b001;
                        if (req_cyc < err_at) err_at = req_cyc;
                    end
                end else begin
                    void'(q.pop_front());
                    if (t + 1 < err_at) err_at = t + 1;
                end
            end else if (t >= req_cyc && g) begin
                void'(q.pop_front());
                m_ov = 1;
                m_of = h;
                if (first) begin
                    m_ot = (h[FW:FW-1] == 2'b00);
                end else if (h[FW] == 1'b0) begin
                    m_ot = 1;
                    if (t + 1 < err_at) err_at = t + 1;
                end else begin
                    m_ot = (h[FW:FW-1] == 2'b11);
                end
                first = 0;
                if (m_ot) active = 0;
            end
        end
        if (accept) q.push_back(f);
        t++;
    endtask

    // Check, drive the next inputs at the falling edge, then step the model
    task automatic cycle(input logic v, input logic [FW:0] f, input logic g);
        @(negedge clk_t);
        compare();
        in_valid = v;
        in_flit  = f;
        sa_grant = g;
        rcu_op   = rcu_flit[2:0];
        model_step(v, f, g);
        @(posedge clk_t);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " rcu_flit"}, rcu_flit, 0);
        chk({tag, " sa_req"}, sa_req, 0);
        chk({tag, " sa_port"}, sa_port, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_flit"}, out_flit, 0);
        chk({tag, " out_tail"}, out_tail, 0);
        chk({tag, " err"}, err, 0);
    endtask

    // Reset asserted between clock edges; outputs must clear at once
    task automatic async_reset();
        #2;
        rst_t = 1'b0;
        #1;
        chk_all_zero("async_rst");
        in_valid = 0;
        sa_grant = 0;
        model_clear();
        @(negedge clk_t);
        @(negedge clk_t);
        rst_t = 1'b1;
    endtask

    task automatic next_flit(output logic [FW:0] f);
        int r;
        logic [2:0] op;
        r  = $urandom_range(0, 99);
        op = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        if (!gen_pkt) begin
            if (r < 5)       f = mk_flit(2'b10, op);
            else if (r < 35) f = mk_flit(2'b00, op);
            else begin
                f = mk_flit(2'b01, op);
                gen_pkt = 1;
            end
        end else begin
            if (r < 5)       f = mk_flit(2'b01, op);
            else if (r < 35) begin
                f = mk_flit(2'b11, op);
                gen_pkt = 0;
            end else         f = mk_flit(2'b10, op);
        end
    endtask

    initial begin
        logic [FW:0] f;
        logic [FW:0] pend;
        logic v, g, acc;

        model_clear();
        t = 0;
        gen_pkt = 0;
        #1;
        chk_all_zero("reset");
        @(negedge clk_t);
        rst_t = 1'b1;
        #1;
        chk("in_ready after release", in_ready, 1);

        // Single flit to x=2, y=1 routed LOCAL
        f = mk_flit(2'b00, 3'b001);
        f[FW-10:FW-13] = 4'd2;
        f[FW-14:FW-17] = 4'd1;
        cycle(1, f, 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        #1;
        chk("single sa_req early", sa_req, 0);
        cycle(0, '0, 0);
        #1;
        chk("single sa_req", sa_req, 1);
        chk("single sa_port", sa_port, 3'b001);
        cycle(0, '0, 1);
        #1;
        chk("single out_valid", out_valid, 1);
        chk("single out_tail", out_tail, 1);
        chk("single out_flit", out_flit, f);
        cycle(0, '0, 0);
        #1;
        chk("single sa_req drop", sa_req, 0);

        // Four-flit packet fills the FIFO; a fifth flit is refused
        cycle(1, mk_flit(2'b01, 3'b010), 0);
        cycle(1, mk_flit(2'b10, 3'b111), 0);
        cycle(1, mk_flit(2'b10, 3'b101), 0);
        cycle(1, mk_flit(2'b11, 3'b011), 0);
        #1;
        chk("full in_ready", in_ready, 0);
        chk("pkt sa_port", sa_port, 3'b010);
        cycle(1, mk_flit(2'b00, 3'b001), 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 1);
            #1;
            chk("pkt out_valid", out_valid, 1);
            chk("pkt out_tail", out_tail, i == 3);
            if (i == 0) chk("in_ready after grant", in_ready, 1);
        end
        chk("no err yet", err, 0);

        // Unroutable head: forced LOCAL, error raised, packet still forwarded
        cycle(1, mk_flit(2'b01, 3'b000), 0);
        cycle(1, mk_flit(2'b11, 3'b110), 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        #1;
        chk("op0 sa_port", sa_port, 3'b001);
        chk("op0 err", err, 1);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        #1;
        chk("op0 tail", out_tail, 1);

        // Reset in the middle of a packet after two of four flits
        cycle(1, mk_flit(2'b01, 3'b100), 0);
        cycle(1, mk_flit(2'b10, 3'b001), 0);
        cycle(1, mk_flit(2'b10, 3'b001), 0);
        cycle(1, mk_flit(2'b11, 3'b001), 0);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        async_reset();
        f = mk_flit(2'b00, 3'b011);
        cycle(1, f, 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        #1;
        chk("post-reset sa_req", sa_req, 1);
        chk("post-reset sa_port", sa_port, 3'b011);
        cycle(0, '0, 1);

        // Orphan body flit in IDLE is dropped and flags err
        cycle(1, mk_flit(2'b10, 3'b001), 0);
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        #1;
        chk("orphan err", err, 1);
        chk("orphan out_valid", out_valid, 0);
        chk("orphan dropped", rcu_flit, 0);

        // Randomized traffic, with one reset partway through
        async_reset();
        next_flit(pend);
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 99) < 60);
            g = ($urandom_range(0, 99) < 65);
            acc = v && (q.size() < DEPTH);
            cycle(v, pend, g);
            if (acc) next_flit(pend);
            if (n == 1500) begin
                async_reset();
                gen_pkt = 0;
                next_flit(pend);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
